// File: rtl/maxpool_ctrl_pkg.sv
// Shared types and helpers for the 1-bit MaxPooling sequencer.
// Derived sizes are functions because they depend on per-instance parameters.
package maxpool_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    localparam int DEF_IW     = 28;
    localparam int DEF_IH     = 28;
    localparam int DEF_PW     = 2;
    localparam int DEF_PH     = 2;
    localparam int DEF_RD_LAT = 1;
    localparam int DEF_AW     = 10;

    // Counter width that can hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Output map dimension; trailing partial windows are dropped.
    function automatic int out_dim(input int in_dim, input int win_dim);
        return in_dim / win_dim;
    endfunction

    function automatic int win_size(input int pw, input int ph);
        return pw * ph;
    endfunction

    localparam int DEF_OW  = out_dim(DEF_IW, DEF_PW);
    localparam int DEF_OH  = out_dim(DEF_IH, DEF_PH);
    localparam int DEF_WIN = win_size(DEF_PW, DEF_PH);

endpackage

// File: rtl/maxpool_ctrl_dly.sv
// DEPTH-deep 1-bit delay line with synchronous flush; aligns the pool enable
// with read data coming back from the feature-map RAM.
module maxpool_ctrl_dly #(
    parameter int DEPTH = 1
) (
    input  logic iCLK,
    input  logic iRSTn,
    input  logic iFLUSH,
    input  logic iD,
    output logic oQ
);

    logic [DEPTH-1:0] sh_q;

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge iCLK or negedge iRSTn) begin
                if (!iRSTn)      sh_q <= '0;
                else if (iFLUSH) sh_q <= '0;
                else             sh_q <= iD;
            end
        end else begin : g_many
            always_ff @(posedge iCLK or negedge iRSTn) begin
                if (!iRSTn)      sh_q <= '0;
                else if (iFLUSH) sh_q <= '0;
                else             sh_q <= {sh_q[DEPTH-2:0], iD};
            end
        end
    endgenerate

    assign oQ = sh_q[DEPTH-1];

endmodule

// File: rtl/maxpool_ctrl.sv
// Window sequencer for the 1-bit MaxPooling cell: reads each PWxPH window,
// drains the read latency, then writes the pooled bit and clears the cell.
// Optional cycle counter output oCYCLES when MAXPOOL_CTRL_PERF_EN is defined.
module maxpool_ctrl
    import maxpool_ctrl_pkg::*;
#(
    parameter int IW     = DEF_IW,
    parameter int IH     = DEF_IH,
    parameter int PW     = DEF_PW,
    parameter int PH     = DEF_PH,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int AW     = DEF_AW
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iSTART,
    input  logic          iSTOP,
    input  logic [AW-1:0] iRD_BASE,
    input  logic [AW-1:0] iWR_BASE,
    output logic          oBUSY,
    output logic          oDONE,
    output logic          oRD_EN,
    output logic [AW-1:0] oRD_ADDR,
    output logic          oPOOL_EN,
    output logic          oPOOL_CLR,
    output logic          oWR_EN,
    output logic [AW-1:0] oWR_ADDR
`ifdef MAXPOOL_CTRL_PERF_EN
    ,
    output logic [31:0]   oCYCLES
`endif
);

    localparam int OW  = out_dim(IW, PW);
    localparam int OH  = out_dim(IH, PH);
    localparam int WIN = win_size(PW, PH);
    localparam int XW  = cnt_w(PW);
    localparam int YW  = cnt_w(PH);
    localparam int OXW = cnt_w(OW);
    localparam int OYW = cnt_w(OH);
    localparam int DW  = cnt_w(RD_LAT);

    state_e          state_q, state_d;
    logic [XW-1:0]   kx_q, kx_d;
    logic [YW-1:0]   ky_q, ky_d;
    logic [OXW-1:0]  ox_q, ox_d;
    logic [OYW-1:0]  oy_q, oy_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [AW-1:0]   rd_base_q, rd_base_d;
    logic [AW-1:0]   wr_base_q, wr_base_d;
    logic            done_q, done_d;
    logic            abort_q, abort_d;

    logic            start_acc;
    logic            stop_act;
    logic            wr_act;
    logic [AW-1:0]   row, col, rd_addr, wr_addr;

    // A start coinciding with oDONE is deferred one cycle.
    assign start_acc = (state_q == ST_IDLE) && iSTART && !done_q;
    assign stop_act  = iSTOP && (state_q != ST_IDLE);

    // Address math wraps modulo 2^AW by construction of the operand widths.
    assign row     = AW'(oy_q) * AW'(PH) + AW'(ky_q);
    assign col     = AW'(ox_q) * AW'(PW) + AW'(kx_q);
    assign rd_addr = rd_base_q + row * AW'(IW) + col;
    assign wr_addr = wr_base_q + AW'(oy_q) * AW'(OW) + AW'(ox_q);

    always_comb begin
        state_d   = state_q;
        kx_d      = kx_q;
        ky_d      = ky_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        dcnt_d    = dcnt_q;
        rd_base_d = rd_base_q;
        wr_base_d = wr_base_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        wr_act    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    rd_base_d = iRD_BASE;
                    wr_base_d = iWR_BASE;
                    kx_d      = '0;
                    ky_d      = '0;
                    ox_d      = '0;
                    oy_d      = '0;
                    dcnt_d    = '0;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                if (kx_q == XW'(PW - 1)) begin
                    kx_d = '0;
                    if (ky_q == YW'(PH - 1)) begin
                        ky_d    = '0;
                        dcnt_d  = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        ky_d = ky_q + YW'(1);
                    end
                end else begin
                    kx_d = kx_q + XW'(1);
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == DW'(RD_LAT - 1)) begin
                    dcnt_d  = '0;
                    state_d = ST_WRITE;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            ST_WRITE: begin
                wr_act  = 1'b1;
                state_d = ST_READ;
                if (ox_q == OXW'(OW - 1)) begin
                    ox_d = '0;
                    if (oy_q == OYW'(OH - 1)) begin
                        oy_d    = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        oy_d = oy_q + OYW'(1);
                    end
                end else begin
                    ox_d = ox_q + OXW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including the write of this cycle.
        if (stop_act) begin
            state_d = ST_IDLE;
            abort_d = 1'b1;
            done_d  = 1'b0;
            wr_act  = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q   <= ST_IDLE;
            kx_q      <= '0;
            ky_q      <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            dcnt_q    <= '0;
            rd_base_q <= '0;
            wr_base_q <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            kx_q      <= kx_d;
            ky_q      <= ky_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            dcnt_q    <= dcnt_d;
            rd_base_q <= rd_base_d;
            wr_base_q <= wr_base_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    assign oRD_EN    = (state_q == ST_READ) && !iSTOP;
    assign oRD_ADDR  = oRD_EN ? rd_addr : '0;
    assign oWR_EN    = wr_act;
    assign oWR_ADDR  = wr_act ? wr_addr : '0;
    // Cell clear rides with the write edge, or follows an abort by one cycle.
    assign oPOOL_CLR = wr_act | abort_q;
    assign oDONE     = done_q;
    assign oBUSY     = (state_q != ST_IDLE) | done_q;

    maxpool_ctrl_dly #(
        .DEPTH (RD_LAT)
    ) u_en_dly (
        .iCLK   (iCLK),
        .iRSTn  (iRSTn),
        .iFLUSH (stop_act),
        .iD     (oRD_EN),
        .oQ     (oPOOL_EN)
    );

`ifdef MAXPOOL_CTRL_PERF_EN
    logic [31:0] cnt_q, cyc_q;

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            cnt_q <= '0;
            cyc_q <= '0;
        end else begin
            if (start_acc)  cnt_q <= '0;
            else if (oBUSY) cnt_q <= cnt_q + 32'd1;
            // The oDONE cycle is itself busy, so it is included in the total.
            if (done_q)     cyc_q <= cnt_q + 32'd1;
        end
    end

    assign oCYCLES = cyc_q;
`endif

endmodule
